psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream stage of the sparse PE: consumes the 16-lane product beat (value, row, col per lane) and scatter-adds each product into an on-chip output-feature-map buffer.
- When the upstream sequencer flags the last beat of an output tile, the buffer drains one entry per handshake in row-major order, then self-clears for the next tile.
- Sits between the PE and the activation/writeback stage.

Parameters:
- col_length, 8, width of one row/col coordinate (signed)
- word_length, 8, width of one product value (signed)
- acc_length, 16, accumulator width (signed, saturating)
- kernel_size, 5, kernel edge
- image_size, 7, input feature-map edge; output edge OUT = image_size-kernel_size+1 (3 by default, 9 entries)
- lanes, 16, products per input beat

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  product beat present
- in_last  in  1  qualifies the beat as the final beat of the tile
- in_ready  out  1  stage accepts a beat (1 only in ACCUM)
- data_in  in  lanes*word_length  signed products, lane i at bits [(i+1)*word_length-1 -: word_length]
- data_in_cols  in  lanes*col_length  signed output column per lane, same packing
- data_in_rows  in  lanes*col_length  signed output row per lane, same packing
- out_valid  out  1  drained entry present
- out_ready  in  1  downstream accepts entry
- out_data  out  acc_length  accumulated signed sum
- out_row  out  col_length  entry row
- out_col  out  col_length  entry column
- out_last  out  1  marks entry (OUT-1,OUT-1)
- busy  out  1  high in DRAIN

Behaviour:
- Reset (rst=0, asynchronous): state=ACCUM; all OUT*OUT accumulators=0; drain index=0; in_ready=1; out_valid=0; out_data/out_row/out_col=0; out_last=0; busy=0. Reset asserted mid-tile or mid-drain discards everything.
- States: ACCUM and DRAIN.
- ACCUM: a beat is accepted when in_valid&in_ready.
  - For each entry (r,c), beat_sum = signed sum of every lane whose row==r and col==c (0 to 16 lanes; 12-bit intermediate is sufficient).
  - At the accepting edge: acc = sat(acc + beat_sum), saturating at +(2^(acc_length-1)-1) and -2^(acc_length-1). Latency 1 edge.
  - Lanes with row or col <0 or >=OUT are dropped silently.
  - Zero-valued lanes are legal and add nothing, so the PE's zeroed idle lanes at (0,0) are harmless.
  - Multiple lanes targeting the same entry in one beat all contribute.
- in_last on an accepted beat: that beat is still accumulated; state becomes DRAIN at the same edge; in_ready=0 from the next cycle.
  - in_last without in_valid is ignored.
  - in_valid while in_ready=0 is not accepted; upstream must hold the beat.
- DRAIN: out_valid=1 with index k (0..OUT*OUT-1).
  - Mapping: out_row=k/OUT, out_col=k%OUT, out_data=acc[k] (registered outputs, valid the cycle after entering DRAIN).
  - Outputs hold stable while out_valid&!out_ready.
  - On handshake: acc[k] cleared to 0, k increments.
  - out_last=1 when k=OUT*OUT-1. Its handshake returns the state to ACCUM, clears k, drops out_valid, and raises in_ready on the next cycle.
- busy = (state==DRAIN).
- Throughput: 1 beat/cycle in ACCUM; 1 entry/cycle in DRAIN with out_ready held high. Tile turnaround = OUT*OUT+1 cycles minimum.

Decomposition:
- Shared package: OUT derivation, saturation min/max constants, state enum {ACCUM, DRAIN}, lane field-extract helper function.
- One sub-module: psum_lane_sum. It takes a beat and a target (r,c) and outputs the matched-lane sum. It is instantiated OUT*OUT times via generate.

Test Plan:
- Reset then one beat: lane0 = 5 at (1,2), other lanes 0 at (0,0), in_last=1. Drain yields 9 entries; entry k=5 = 5; all others 0; out_last only on k=8.
- Collision: one beat with all 16 lanes = -3 at (0,0), a second beat lane0 = +10 at (0,0) with in_last. Entry (0,0) = -38.
- Out-of-range: lanes at row 3, col -1, and row -2 carrying 100. All entries stay 0.
- Saturation: 300 beats each with 16 lanes of 127 at (2,2). Entry (2,2) = 32767. Repeat with -128: result -32768.
- Backpressure: toggle out_ready 1,0,0,1,... during drain. Each entry is emitted exactly once in row-major order with stable fields while stalled, and in_valid during DRAIN is not accepted. After drain, a new tile starts from all-zero accumulators.
- Reset mid-drain: pull rst low at k=4. out_valid drops immediately, in_ready=1 after release, and the next tile drains zeros except new contributions.

Source files
------------

// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator slice.
//   - psum_state_t : accumulate / drain controller states
//   - out_edge()   : output feature-map edge derived from image and kernel size
//   - sat_max/min  : saturation limits of a signed accumulator of a given width
//   - lane_field() : sign-extended extraction of one packed lane field
package psum_accumulator_pkg;

    // Widest packed lane vector lane_field() can see (lanes * field width).
    localparam int MAX_VEC = 1024;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } psum_state_t;

    function automatic int out_edge(input int image_size, input int kernel_size);
        return image_size - kernel_size + 1;
    endfunction

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

    // Lane idx occupies bits [(idx+1)*width-1 -: width]; the result is
    // sign-extended to 32 bits so it compares directly against int targets.
    function automatic logic signed [31:0] lane_field(input logic [MAX_VEC-1:0] vec,
                                                      input int idx,
                                                      input int width);
        logic [31:0] raw;
        raw = 32'(vec >> (idx * width));
        return $signed(raw << (32 - width)) >>> (32 - width);
    endfunction

endpackage

// File: rtl/psum_lane_sum.sv
// Matched-lane adder for one output-feature-map entry.
// Sums every lane of the incoming beat whose (row, col) equals this
// instance's (target_row, target_col). Lanes aimed anywhere else, including
// out-of-range coordinates, contribute nothing.
//   data_in      : lanes signed products
//   data_in_rows : lanes signed row coordinates
//   data_in_cols : lanes signed column coordinates
//   lane_sum     : signed sum of the matching lanes (0 when none match)
module psum_lane_sum
    import psum_accumulator_pkg::*;
#(
    parameter int lanes       = 16,
    parameter int word_length = 8,
    parameter int col_length  = 8,
    parameter int target_row  = 0,
    parameter int target_col  = 0,
    // Worst case is every lane at full negative scale: lanes * -2^(word_length-1).
    parameter int sum_width   = word_length + $clog2(lanes)
) (
    input  logic [lanes*word_length-1:0] data_in,
    input  logic [lanes*col_length-1:0]  data_in_rows,
    input  logic [lanes*col_length-1:0]  data_in_cols,
    output logic [sum_width-1:0]         lane_sum
);

    logic signed [sum_width-1:0] sum;

    // NOTE: combinational accumulation uses blocking '=' so each loop
    // iteration sees the previous partial sum; the default at the top keeps
    // the block free of inferred latches.
    always_comb begin
        sum = '0;
        for (int i = 0; i < lanes; i++) begin
            if (lane_field(MAX_VEC'(data_in_rows), i, col_length) == target_row &&
                lane_field(MAX_VEC'(data_in_cols), i, col_length) == target_col) begin
                sum = sum + sum_width'(lane_field(MAX_VEC'(data_in), i, word_length));
            end
        end
    end

    assign lane_sum = sum;

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: scatter-adds 16-lane product beats into an
// OUT x OUT saturating accumulator buffer, then drains it row-major over a
// valid/ready handshake and clears each entry as it leaves.
//   clk, rst                       : clock (rising edge), async active-low reset
//   in_valid, in_ready, in_last    : product beat handshake; in_last ends the tile
//   data_in, data_in_rows/cols     : per-lane signed product and target coordinate
//   out_valid, out_ready, out_last : drained entry handshake; out_last on final entry
//   out_data, out_row, out_col     : accumulated sum and its coordinate
//   busy                           : high while draining
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int col_length  = 8,
    parameter int word_length = 8,
    parameter int acc_length  = 16,
    parameter int kernel_size = 5,
    parameter int image_size  = 7,
    parameter int lanes       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    input  logic [lanes*word_length-1:0]  data_in,
    input  logic [lanes*col_length-1:0]   data_in_cols,
    input  logic [lanes*col_length-1:0]   data_in_rows,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [acc_length-1:0]         out_data,
    output logic [col_length-1:0]         out_row,
    output logic [col_length-1:0]         out_col,
    output logic                          out_last,
    output logic                          busy
);

    localparam int out_size  = out_edge(image_size, kernel_size);
    localparam int n_entries = out_size * out_size;
    localparam int idx_width = (n_entries > 1) ? $clog2(n_entries) : 1;
    localparam int sum_width = word_length + $clog2(lanes);

    localparam logic signed [acc_length-1:0] acc_max = acc_length'(sat_max(acc_length));
    localparam logic signed [acc_length-1:0] acc_min = acc_length'(sat_min(acc_length));
    // One guard bit is enough: |beat sum| is far below 2^(acc_length-1).
    localparam logic signed [acc_length:0]   wide_max = (acc_length+1)'(acc_max);
    localparam logic signed [acc_length:0]   wide_min = (acc_length+1)'(acc_min);

    psum_state_t state, state_next;

    logic                        accept;
    logic                        drain_fire;
    logic                        drain_last;
    logic [idx_width-1:0]        drain_idx;
    logic [col_length-1:0]       drain_row;
    logic [col_length-1:0]       drain_col;

    logic signed [acc_length-1:0] acc      [n_entries];
    logic signed [acc_length-1:0] acc_next [n_entries];
    logic [sum_width-1:0]         lane_sum [n_entries];

    // ------------------------------------------------------------------
    // Per-entry matched-lane sum and saturating next value
    // ------------------------------------------------------------------
    for (genvar k = 0; k < n_entries; k++) begin : g_entry
        logic signed [acc_length:0] wide_sum;

        psum_lane_sum #(
            .lanes       (lanes),
            .word_length (word_length),
            .col_length  (col_length),
            .target_row  (k / out_size),
            .target_col  (k % out_size),
            .sum_width   (sum_width)
        ) u_lane_sum (
            .data_in      (data_in),
            .data_in_rows (data_in_rows),
            .data_in_cols (data_in_cols),
            .lane_sum     (lane_sum[k])
        );

        assign wide_sum = (acc_length+1)'(acc[k]) + (acc_length+1)'($signed(lane_sum[k]));

        assign acc_next[k] = (wide_sum > wide_max) ? acc_max :
                             (wide_sum < wide_min) ? acc_min :
                             wide_sum[acc_length-1:0];
    end

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    assign drain_last = (drain_idx == idx_width'(n_entries - 1));

    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        drain_fire = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                drain_fire = out_ready;
                if (out_ready && drain_last) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // ------------------------------------------------------------------
    // Drain index, kept alongside its row/col split to avoid a divider
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_idx <= '0;
            drain_row <= '0;
            drain_col <= '0;
        end else if (drain_fire) begin
            if (drain_last) begin
                drain_idx <= '0;
                drain_row <= '0;
                drain_col <= '0;
            end else begin
                drain_idx <= drain_idx + 1'b1;
                if (drain_col == col_length'(out_size - 1)) begin
                    drain_col <= '0;
                    drain_row <= drain_row + 1'b1;
                end else begin
                    drain_col <= drain_col + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator buffer
    // ------------------------------------------------------------------
    // NOTE: the buffer is only OUT*OUT flops and a reset mid-tile must
    // discard partial sums, so every entry is reset rather than left as RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < n_entries; k++) begin
                acc[k] <= '0;
            end
        end else begin
            for (int k = 0; k < n_entries; k++) begin
                if (accept) begin
                    acc[k] <= acc_next[k];
                end else if (drain_fire && drain_idx == idx_width'(k)) begin
                    acc[k] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output view: a register-only mux, forced to zero outside DRAIN
    // ------------------------------------------------------------------
    always_comb begin
        out_data = '0;
        for (int k = 0; k < n_entries; k++) begin
            if (state == DRAIN && drain_idx == idx_width'(k)) begin
                out_data = acc[k];
            end
        end
    end

    assign out_row  = drain_row;
    assign out_col  = drain_col;
    assign out_last = (state == DRAIN) && drain_last;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed and randomized tiles compared against
// an arithmetic model of the OUT x OUT saturating buffer.
module tb_psum_accumulator;

    localparam int LANES = 16;
    localparam int WL    = 8;
    localparam int CL    = 8;
    localparam int AL    = 16;
    localparam int OUT   = 3;
    localparam int N     = OUT * OUT;
    localparam int AMAX  = 32767;
    localparam int AMIN  = -32768;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_last = 1'b0;
    logic                  out_ready = 1'b0;
    logic                  in_ready, out_valid, out_last, busy;
    logic [LANES*WL-1:0]   data_in = '0;
    logic [LANES*CL-1:0]   data_in_rows = '0;
    logic [LANES*CL-1:0]   data_in_cols = '0;
    logic [AL-1:0]         out_data;
    logic [CL-1:0]         out_row, out_col;

    int n_cmp = 0;
    int n_err = 0;
    int model [N];

    always #5 clk = ~clk;

    psum_accumulator #(
        .col_length  (CL),
        .word_length (WL),
        .acc_length  (AL),
        .kernel_size (5),
        .image_size  (7),
        .lanes       (LANES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .data_in_cols (data_in_cols),
        .data_in_rows (data_in_rows),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .busy         (busy)
    );

    // ---------------- reference model ----------------
    function automatic int sat(input int v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    task automatic model_clear();
        for (int e = 0; e < N; e++) model[e] = 0;
    endtask

    // Gather the beat per entry first, then saturate once per entry.
    task automatic model_beat();
        int bsum [N];
        for (int e = 0; e < N; e++) bsum[e] = 0;
        for (int i = 0; i < LANES; i++) begin
            logic signed [WL-1:0] v;
            logic signed [CL-1:0] r;
            logic signed [CL-1:0] c;
            v = data_in[i*WL +: WL];
            r = data_in_rows[i*CL +: CL];
            c = data_in_cols[i*CL +: CL];
            if (r >= 0 && r < OUT && c >= 0 && c < OUT)
                bsum[int'(r) * OUT + int'(c)] += int'(v);
        end
        for (int e = 0; e < N; e++) model[e] = sat(model[e] + bsum[e]);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_beat();
        data_in = '0;
        data_in_rows = '0;
        data_in_cols = '0;
    endtask

    task automatic set_lane(input int i, input int v, input int r, input int c);
        data_in[i*WL +: WL]      = v[WL-1:0];
        data_in_rows[i*CL +: CL] = r[CL-1:0];
        data_in_cols[i*CL +: CL] = c[CL-1:0];
    endtask

    task automatic random_beat();
        for (int i = 0; i < LANES; i++)
            set_lane(i, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 4)) - 1);
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic send_beat(input string tag, input bit last);
        in_valid = 1'b1;
        in_last  = last;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready: got %b want 1", tag, in_ready);
        end
        @(posedge clk);
        model_beat();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: out_ready always 1; 1: pattern 1,0,0,1; 2: random.
    // poke: offer random beats while draining (must be refused).
    task automatic drain_and_compare(input string tag, input int mode, input bit poke,
                                     input int stop_after);
        int k = 0;
        int cyc = 0;
        int pat = 0;
        while (k < stop_after && cyc < 400) begin
            bit rdy;
            logic [AL-1:0] exp_d;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (pat % 4 == 0) || (pat % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pat++;
            if (poke) begin
                random_beat();
                in_valid = 1'b1;
                in_last  = 1'($urandom_range(0, 1));
            end
            exp_d = model[k][AL-1:0];
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_row !== CL'(k / OUT) ||
                out_col !== CL'(k % OUT) || out_last !== (k == N - 1) ||
                busy !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s entry %0d: got v=%b d=%0d r=%0d c=%0d l=%b b=%b ir=%b want v=1 d=%0d r=%0d c=%0d l=%b b=1 ir=0",
                         tag, k, out_valid, $signed(out_data), out_row, out_col, out_last, busy,
                         in_ready, $signed(exp_d), k / OUT, k % OUT, k == N - 1);
            end
            out_ready = rdy;
            @(posedge clk);
            if (rdy) begin
                model[k] = 0;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        clear_beat();
        if (k < stop_after) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: drained %0d want %0d", tag, k, stop_after);
        end else if (stop_after == N) begin
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL %s after_drain: got v=%b ir=%b b=%b want v=0 ir=1 b=0",
                         tag, out_valid, in_ready, busy);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_row !== '0 ||
            out_col !== '0 || out_last !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got ir=%b v=%b d=%0d r=%0d c=%0d l=%b b=%b want 1 0 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_row, out_col, out_last, busy);
        end
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ir=%b b=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_single();
        clear_beat();
        set_lane(0, 5, 1, 2);
        send_beat("single", 1'b1);
        drain_and_compare("single", 0, 1'b0, N);
    endtask

    task automatic test_collision();
        clear_beat();
        for (int i = 0; i < LANES; i++) set_lane(i, -3, 0, 0);
        send_beat("collision_a", 1'b0);
        clear_beat();
        set_lane(0, 10, 0, 0);
        send_beat("collision_b", 1'b1);
        drain_and_compare("collision", 0, 1'b0, N);
    endtask

    task automatic test_out_of_range();
        clear_beat();
        set_lane(0, 100, 3, 1);
        set_lane(1, 100, 1, -1);
        set_lane(2, 100, -2, 0);
        set_lane(3, 100, 0, 3);
        send_beat("out_of_range", 1'b1);
        drain_and_compare("out_of_range", 0, 1'b0, N);
    endtask

    task automatic test_last_without_valid();
        clear_beat();
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL last_without_valid: got b=%b ir=%b want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_saturation(input int v);
        clear_beat();
        for (int i = 0; i < LANES; i++) set_lane(i, v, 2, 2);
        for (int b = 0; b < 300; b++) send_beat("saturation", b == 299);
        drain_and_compare(v > 0 ? "sat_pos" : "sat_neg", 0, 1'b0, N);
    endtask

    task automatic test_backpressure();
        for (int b = 0; b < 3; b++) begin
            random_beat();
            send_beat("backpressure", b == 2);
        end
        drain_and_compare("backpressure", 1, 1'b1, N);
        clear_beat();
        set_lane(5, 7, 0, 1);
        send_beat("post_bp", 1'b1);
        drain_and_compare("post_bp", 0, 1'b0, N);
    endtask

    task automatic test_random_tiles();
        for (int t = 0; t < 6; t++) begin
            int nb;
            nb = int'($urandom_range(1, 6));
            for (int b = 0; b < nb; b++) begin
                random_beat();
                send_beat("random", b == nb - 1);
            end
            drain_and_compare("random", 2, 1'b1, N);
        end
    endtask

    task automatic test_reset_mid_drain();
        random_beat();
        send_beat("mid_drain", 1'b1);
        drain_and_compare("mid_drain_pre", 0, 1'b0, 4);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL mid_drain_reset: got v=%b b=%b l=%b want 0 0 0", out_valid, busy, out_last);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_drain_release: got ir=%b v=%b want 1 0", in_ready, out_valid);
        end
        clear_beat();
        set_lane(0, -9, 2, 0);
        set_lane(7, 4, 0, 0);
        send_beat("post_reset", 1'b1);
        drain_and_compare("post_reset", 0, 1'b0, N);
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_single();
        test_collision();
        test_out_of_range();
        test_last_without_valid();
        test_saturation(127);
        test_saturation(-128);
        test_backpressure();
        test_random_tiles();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
